// File: rtl/ibus_loader_if.sv
// ibus_loader_if
// Bundles the byte-stream handshake and the instruction-memory write port
// used by the program loader.
//   master : host side (drives start / in_valid / in_data, observes the rest)
//   slave  : loader side (ibus_loader)
// Signals:
//   start    - one-cycle pulse that begins a load
//   in_valid - byte available on in_data
//   in_data  - stream byte
//   in_ready - loader accepts a byte this cycle
//   wr_en    - one-cycle instruction memory write strobe
//   wr_addr  - word address
//   wr_data  - instruction word
//   cpu_hold - keeps the core off the fetch bus
//   done     - last load completed with a good checksum
//   err      - last load was aborted
interface ibus_loader_if;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
    );
endinterface

// File: rtl/ibus_loader.sv
// ibus_loader
// Receives a program image as a byte stream (LEN_H, LEN_L, N x (DAT_H, DAT_L),
// CSUM), assembles 16-bit words and writes them into the instruction memory
// from address 0 upward. The core is held off the fetch bus while loading
// and after an aborted load.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - ibus_loader_if.slave (byte handshake, memory write port, status)
// Parameter:
//   ROM_AW - instruction memory address width (2**ROM_AW words)
module ibus_loader #(
    parameter int ROM_AW = 7
) (
    input logic          clk,
    input logic          rst,
    ibus_loader_if.slave bus
);
    localparam int         CW  = ROM_AW + 1;
    localparam logic [16:0] CAP = 17'(2 ** ROM_AW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_H,
        S_LEN_L,
        S_DAT_H,
        S_DAT_L,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state, state_nx;
    logic [7:0]      len_hi;
    logic [15:0]     n_words;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [7:0]      csum;
    logic [7:0]      hi_byte;
    logic [15:0]     len_full;
    logic            byte_acc;
    logic            len_over;
    logic            last_word;

    // Status outputs decode directly from the state register.
    assign bus.in_ready = (state == S_LEN_H) || (state == S_LEN_L) ||
                          (state == S_DAT_H) || (state == S_DAT_L) ||
                          (state == S_CSUM);
    assign bus.cpu_hold = bus.in_ready || (state == S_ERR);
    assign bus.done     = (state == S_DONE);
    assign bus.err      = (state == S_ERR);

    assign byte_acc  = bus.in_valid & bus.in_ready;
    assign len_full  = {len_hi, bus.in_data};
    assign len_over  = {1'b0, len_full} > CAP;
    assign cnt_inc   = cnt + CW'(1);
    // cnt counts words already written; cnt_inc == N means this is the last one.
    assign last_word = (16'(cnt_inc) == n_words);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) state_nx = S_LEN_H;
            end
            S_LEN_H: begin
                if (byte_acc) state_nx = S_LEN_L;
            end
            S_LEN_L: begin
                if (byte_acc) begin
                    if (len_over)             state_nx = S_ERR;
                    else if (len_full == '0)  state_nx = S_CSUM;
                    else                      state_nx = S_DAT_H;
                end
            end
            S_DAT_H: begin
                if (byte_acc) state_nx = S_DAT_L;
            end
            S_DAT_L: begin
                if (byte_acc) state_nx = last_word ? S_CSUM : S_DAT_H;
            end
            S_CSUM: begin
                if (byte_acc) state_nx = (bus.in_data == csum) ? S_DONE : S_ERR;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            len_hi      <= '0;
            n_words     <= '0;
            cnt         <= '0;
            csum        <= '0;
            hi_byte     <= '0;
        end else begin
            state     <= state_nx;
            bus.wr_en <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        cnt  <= '0;
                        csum <= '0;
                    end
                end
                S_LEN_H: begin
                    if (byte_acc) len_hi <= bus.in_data;
                end
                S_LEN_L: begin
                    if (byte_acc) n_words <= len_full;
                end
                S_DAT_H: begin
                    if (byte_acc) begin
                        hi_byte <= bus.in_data;
                        csum    <= csum ^ bus.in_data;
                    end
                end
                S_DAT_L: begin
                    // N <= 2**ROM_AW was checked, so cnt never exceeds the top address here.
                    if (byte_acc) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= 16'(cnt[ROM_AW-1:0]);
                        bus.wr_data <= {hi_byte, bus.in_data};
                        csum        <= csum ^ bus.in_data;
                        cnt         <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ibus_loader.sv
module tb_ibus_loader;
    localparam int ROM_AW = 7;

    logic clk = 1'b0;
    logic rst;

    ibus_loader_if bus();

    ibus_loader #(.ROM_AW(ROM_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          vecs = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];     // {addr, data} of every write the model predicts
    bit          exp_done;
    bit          exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next predicted write.
    always begin
        @(posedge clk);
        #1;
        if (bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                vecs++;
                miscompares++;
                $display("FAIL unexpected write: got addr %h data %h, expected none",
                         bus.wr_addr, bus.wr_data);
            end else begin
                check("write", {bus.wr_addr, bus.wr_data}, exp_q.pop_front());
            end
        end
    end

    // Reference model: parse the frame by its byte layout.
    task automatic model(input logic [7:0] f[$], input bit complete);
        int         n;
        logic [7:0] x;
        n = int'({f[0], f[1]});
        x = 8'h00;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (n > (1 << ROM_AW)) begin
            exp_err = 1'b1;
            return;
        end
        for (int w = 0; w < n && (3 + 2 * w) < f.size(); w++) begin
            exp_q.push_back({16'(w), f[2 + 2 * w], f[3 + 2 * w]});
            x = x ^ f[2 + 2 * w] ^ f[3 + 2 * w];
        end
        if (complete) begin
            if (f[2 + 2 * n] == x) exp_done = 1'b1;
            else                   exp_err  = 1'b1;
        end
    endtask

    task automatic make_frame(input int n, input bit corrupt, output logic [7:0] q[$]);
        logic [7:0] x;
        logic [7:0] b;
        q = {};
        x = 8'h00;
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            q.push_back(b);
            x = x ^ b;
        end
        if (corrupt) x = x ^ 8'($urandom_range(1, 255));
        q.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall_pct, input bit st);
        int t;
        if ($urandom_range(0, 99) < stall_pct) begin
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.start    = 1'b0;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.start    = st;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            bus.start = 1'b0;
            t++;
        end
        if (t >= 200) begin
            check("in_ready timeout", 32'(bus.in_ready), 32'(1));
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
    endtask

    task automatic run_frame(input logic [7:0] f[$], input int stall_pct,
                             input int start_at, input bit complete);
        model(f, complete);
        // start together with a byte offered: the byte must not be consumed
        @(negedge clk);
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check("hold at load start", 32'(bus.cpu_hold), 32'(1));
        check("ready at load start", 32'(bus.in_ready), 32'(1));
        check("done cleared by start", 32'(bus.done), 32'(0));
        check("err cleared by start", 32'(bus.err), 32'(0));
        for (int i = 0; i < f.size(); i++) send_byte(f[i], stall_pct, i == start_at);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (complete) begin
            check("done", 32'(bus.done), 32'(exp_done));
            check("err", 32'(bus.err), 32'(exp_err));
            check("cpu_hold after load", 32'(bus.cpu_hold), 32'(exp_err));
            check("in_ready after load", 32'(bus.in_ready), 32'(0));
            repeat (2) @(negedge clk);
            check("writes outstanding", 32'(exp_q.size()), 32'(0));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'(0));
        check({tag, " wr_en"}, 32'(bus.wr_en), 32'(0));
        check({tag, " wr_addr"}, 32'(bus.wr_addr), 32'(0));
        check({tag, " wr_data"}, 32'(bus.wr_data), 32'(0));
        check({tag, " cpu_hold"}, 32'(bus.cpu_hold), 32'(0));
        check({tag, " done"}, 32'(bus.done), 32'(0));
        check({tag, " err"}, 32'(bus.err), 32'(0));
    endtask

    initial begin
        logic [7:0] f[$];
        logic [7:0] normal[$];

        // Checksum byte 0xBF = 12^34^AB^CD^00^FF.
        normal = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'hBF};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_frame(normal, 0, -1, 1'b1);

        f = '{8'h00, 8'h00, 8'h00};
        run_frame(f, 0, -1, 1'b1);

        f = '{8'h00, 8'h81};
        run_frame(f, 0, -1, 1'b1);

        f = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
        run_frame(f, 0, -1, 1'b1);

        run_frame(normal, 50, -1, 1'b1);

        // Reset after the 4th byte; the first word's write is already out.
        f = '{8'h00, 8'h03, 8'h12, 8'h34};
        run_frame(f, 0, -1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid-load reset");
        rst = 1'b0;
        check("writes before reset", 32'(exp_q.size()), 32'(0));

        run_frame(normal, 0, -1, 1'b1);

        // start pulsed with the first DAT_H byte
        run_frame(normal, 0, 2, 1'b1);

        make_frame(1 << ROM_AW, 1'b0, f);
        run_frame(f, 0, -1, 1'b1);

        f = '{8'h01, 8'h00};
        run_frame(f, 0, -1, 1'b1);

        for (int k = 0; k < 8; k++) begin
            make_frame($urandom_range(0, 12), ($urandom_range(0, 3) == 0), f);
            run_frame(f, 30, -1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
